// File: rtl/inst_queue_2w.sv
// Dual-lane instruction queue between fetch and the two decoders.
// Circular buffer, up to 2 pushes and 2 pops per cycle, flush clears all entries.
module inst_queue_2w #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_pc1,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  input  logic [1:0]       out_pop,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PUSH_LIM = (PTR_W+1)'(DEPTH - 2);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [1:0]       push_want;
  logic [1:0]       npush;
  logic [1:0]       pop_eff;
  logic [1:0]       npop;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  assign in_ready  = (count <= PUSH_LIM);
  assign out_valid = {count >= (PTR_W+1)'(2), count != '0};

  always_comb begin
    push_want = 2'd0;
    pop_eff   = 2'b00;
    case (in_valid)
      2'b01:   push_want = 2'd1;
      2'b11:   push_want = 2'd2;
      default: push_want = 2'd0;
    endcase
    // A pop on a lane without a valid entry is silently ignored.
    case (out_pop)
      2'b01:   pop_eff = {1'b0, out_valid[0]};
      2'b11:   pop_eff = out_valid;
      default: pop_eff = 2'b00;
    endcase
    npush = in_ready ? push_want : 2'd0;
    npop  = {1'b0, pop_eff[0]} + {1'b0, pop_eff[1]};
  end

  always_comb begin
    out_inst0 = '0;
    out_pc0   = '0;
    out_inst1 = '0;
    out_pc1   = '0;
    if (out_valid[0]) begin
      out_inst0 = mem[head][63:32];
      out_pc0   = mem[head][31:0];
    end
    if (out_valid[1]) begin
      out_inst1 = mem[head_p1][63:32];
      out_pc1   = mem[head_p1][31:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_want != 2'd0)
        assert (in_ready) else $warning("inst_queue_2w: push dropped, queue full");
      tail  <= tail + PTR_W'(npush);
      head  <= head + PTR_W'(npop);
      count <= count + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rstn && !flush && npush != 2'd0) begin
      mem[tail] <= {in_inst0, in_pc0};
      if (npush == 2'd2)
        mem[tail_p1] <= {in_inst1, in_pc1};
    end
  end

endmodule

// File: tb/tb_inst_queue_2w.sv
// Directed bench for inst_queue_2w (DEPTH=8) with hand-computed expectations.
module tb_inst_queue_2w;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
  logic [1:0]  out_pop;
  logic [3:0]  count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  inst_queue_2w #(.DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_pop(out_pop), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                     input logic [31:0] i1, input logic [31:0] p1,
                     input logic [1:0] pop, input logic fl);
    in_valid = v;  in_inst0 = i0; in_pc0 = p0; in_inst1 = i1; in_pc1 = p1;
    out_pop  = pop; flush = fl;
    @(posedge clk);
    #1;
    in_valid = 2'b00; out_pop = 2'b00; flush = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
    in_inst0 = '0; in_inst1 = '0; in_pc0 = '0; in_pc1 = '0;
    #12 rstn = 1'b1;
    @(posedge clk); #1;

    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_inst0", out_inst0, 32'h0);

    // single push then pop; lane 1 outputs forced to zero while invalid
    cyc(2'b01, 32'h02800421, 32'h1c000000, 32'hdeadbeef, 32'hdeadbeef, 2'b00, 1'b0);
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_inst0", out_inst0, 32'h02800421);
    check("one_pc0",   out_pc0,   32'h1c000000);
    check("one_inst1_zero", out_inst1, 32'h0);
    cyc(2'b00, '0, '0, '0, '0, 2'b01, 1'b0);
    check("one_pop_count", 32'(count), 32'd0);
    check("one_pop_valid", 32'(out_valid), 32'd0);

    // fill: at count=6 a pair still fits, at 8 pushes are refused
    for (int k = 0; k < 3; k++)
      cyc(2'b11, 32'h10 + 32'(2*k), 32'h1000 + 32'(8*k), 32'h11 + 32'(2*k), 32'h1004 + 32'(8*k), 2'b00, 1'b0);
    check("fill6_count", 32'(count), 32'd6);
    check("fill6_ready", 32'(in_ready), 32'd1);
    cyc(2'b11, 32'h16, 32'h1018, 32'h17, 32'h101c, 2'b00, 1'b0);
    check("fill8_count", 32'(count), 32'd8);
    check("fill8_ready", 32'(in_ready), 32'd0);
    cyc(2'b11, 32'hee, 32'hee, 32'hef, 32'hef, 2'b00, 1'b0);
    check("drop_count", 32'(count), 32'd8);
    check("full_inst0", out_inst0, 32'h10);
    check("full_inst1", out_inst1, 32'h11);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("pop_full_count", 32'(count), 32'd6);
    check("pop_full_ready", 32'(in_ready), 32'd1);
    check("pop_full_inst0", out_inst0, 32'h12);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("drain_inst0", out_inst0, 32'h14);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("drain_inst0b", out_inst0, 32'h16);
    check("drain_inst1b", out_inst1, 32'h17);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("drain_count", 32'(count), 32'd0);

    // wrap: flush to zero pointers, then move head=tail to 7
    cyc(2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) cyc(2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 2'b00, 1'b0);
    cyc(2'b01, 32'h3, 32'h3, '0, '0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    cyc(2'b00, '0, '0, '0, '0, 2'b01, 1'b0);
    check("pre_wrap_count", 32'(count), 32'd0);
    cyc(2'b11, 32'ha0, 32'h100, 32'ha1, 32'h104, 2'b00, 1'b0);
    check("wrap_pc0",   out_pc0,   32'h100);
    check("wrap_pc1",   out_pc1,   32'h104);
    check("wrap_inst1", out_inst1, 32'ha1);
    cyc(2'b11, 32'ha2, 32'h108, 32'ha3, 32'h10c, 2'b00, 1'b0);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("wrap_pop_pc0", out_pc0, 32'h108);
    check("wrap_pop_pc1", out_pc1, 32'h10c);
    check("wrap_pop_count", 32'(count), 32'd2);

    // simultaneous push/pop at count=2, then masked encodings
    cyc(2'b11, 32'hc0, 32'h200, 32'hc1, 32'h204, 2'b11, 1'b0);
    check("sim_count", 32'(count), 32'd2);
    check("sim_pc0", out_pc0, 32'h200);
    check("sim_pc1", out_pc1, 32'h204);
    cyc(2'b00, '0, '0, '0, '0, 2'b10, 1'b0);
    check("pop10_count", 32'(count), 32'd2);
    check("pop10_pc0", out_pc0, 32'h200);
    cyc(2'b10, 32'hff, 32'hff, 32'hff, 32'hff, 2'b00, 1'b0);
    check("push10_count", 32'(count), 32'd2);
    cyc(2'b00, '0, '0, '0, '0, 2'b01, 1'b0);
    check("pop1_count", 32'(count), 32'd1);
    check("pop1_valid", 32'(out_valid), 32'd1);
    check("pop1_pc0", out_pc0, 32'h204);
    check("pop1_pc1_zero", out_pc1, 32'h0);
    cyc(2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
    check("pop11_at1_count", 32'(count), 32'd0);

    // flush wins over same-cycle push and pop
    cyc(2'b11, 32'hd0, 32'h300, 32'hd1, 32'h304, 2'b00, 1'b0);
    cyc(2'b11, 32'hd2, 32'h308, 32'hd3, 32'h30c, 2'b00, 1'b0);
    check("pre_flush_count", 32'(count), 32'd4);
    cyc(2'b11, 32'hd4, 32'h400, 32'hd5, 32'h404, 2'b11, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    cyc(2'b01, 32'hb0, 32'h500, '0, '0, 2'b00, 1'b0);
    check("post_flush_inst0", out_inst0, 32'hb0);
    check("post_flush_pc0", out_pc0, 32'h500);
    check("post_flush_count", 32'(count), 32'd1);

    // asynchronous reset mid-run with count=5
    cyc(2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 2'b00, 1'b0);
    cyc(2'b11, 32'h3, 32'h3, 32'h4, 32'h4, 2'b00, 1'b0);
    check("pre_rst_count", 32'(count), 32'd5);
    #2 rstn = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_inst0", out_inst0, 32'h0);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
